// File: rtl/decode_fwd_stage_if.sv
// Bus bundle for decode_fwd_stage: IF/ID inputs, WB/forwarding sideband and the
// ID/EX register outputs. The upstream/driver side uses master, the stage uses slave.
interface decode_fwd_stage_if #(
   parameter int XLEN      = 32,
   parameter int FWD_DEPTH = 2,
   parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
);
   logic                   stall;
   logic                   flush;
   logic [XLEN-1:0]        instr_IFID;
   logic [XLEN-1:0]        pc_addr_IFID;
   logic                   valid_IFID;
   logic                   taken_IFID;
   logic                   wb_load;
   logic [4:0]             wb_rd;
   logic [XLEN-1:0]        wb_data;
   logic [FWD_DEPTH-1:0]   fwd_load_regfile;
   logic [FWD_DEPTH-1:0]   fwd_mem_read;
   logic [5*FWD_DEPTH-1:0] fwd_rd;

   logic                   hazard_stall;
   logic [XLEN-1:0]        rs1_data_IDEX;
   logic [XLEN-1:0]        rs2_data_IDEX;
   logic [XLEN-1:0]        imm_IDEX;
   logic [XLEN-1:0]        pc_addr_IDEX;
   logic [4:0]             rd_IDEX;
   logic [2:0]             funct3_IDEX;
   logic [6:0]             funct7_IDEX;
   logic [6:0]             opcode_IDEX;
   logic [SEL_W-1:0]       rs1_sel_IDEX;
   logic [SEL_W-1:0]       rs2_sel_IDEX;
   logic                   valid_IDEX;
   logic                   load_regfile_IDEX;
   logic                   taken_IDEX;

   modport master (
      output stall, flush, instr_IFID, pc_addr_IFID, valid_IFID, taken_IFID,
             wb_load, wb_rd, wb_data, fwd_load_regfile, fwd_mem_read, fwd_rd,
      input  hazard_stall, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX, pc_addr_IDEX,
             rd_IDEX, funct3_IDEX, funct7_IDEX, opcode_IDEX, rs1_sel_IDEX,
             rs2_sel_IDEX, valid_IDEX, load_regfile_IDEX, taken_IDEX
   );

   modport slave (
      input  stall, flush, instr_IFID, pc_addr_IFID, valid_IFID, taken_IFID,
             wb_load, wb_rd, wb_data, fwd_load_regfile, fwd_mem_read, fwd_rd,
      output hazard_stall, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX, pc_addr_IDEX,
             rd_IDEX, funct3_IDEX, funct7_IDEX, opcode_IDEX, rs1_sel_IDEX,
             rs2_sel_IDEX, valid_IDEX, load_regfile_IDEX, taken_IDEX
   );
endinterface

// File: rtl/decode_fwd_stage.sv
// RV32I decode stage: regfile, field/immediate decode, forwarding select, load-use bubble.
// Define RF_BYPASS_EN for write-through regfile reads; otherwise a WB/read collision stalls.

module decode_fwd_sel #(
   parameter int FWD_DEPTH = 2,
   parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
   input  logic [4:0]             rs,
   input  logic                   used,
   input  logic [FWD_DEPTH-1:0]   fwd_load_regfile,
   input  logic [5*FWD_DEPTH-1:0] fwd_rd,
   output logic [SEL_W-1:0]       sel
);
   // Scan far-to-near so the nearest matching stage is the one left in sel.
   always_comb begin
      sel = '0;
      for (int k = FWD_DEPTH - 1; k >= 0; k--)
         if (used && rs != 5'd0 && fwd_load_regfile[k] && fwd_rd[5*k +: 5] == rs)
            sel = SEL_W'(k + 1);
   end
endmodule

module decode_fwd_stage #(
   parameter int XLEN      = 32,
   parameter int NUM_REGS  = 32,
   parameter int FWD_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   decode_fwd_stage_if.slave  bus
);
   localparam int SEL_W = $clog2(FWD_DEPTH + 1);
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   typedef struct packed {
      logic [XLEN-1:0]  rs1_data;
      logic [XLEN-1:0]  rs2_data;
      logic [XLEN-1:0]  imm;
      logic [XLEN-1:0]  pc_addr;
      logic [4:0]       rd;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [6:0]       opcode;
      logic [SEL_W-1:0] rs1_sel;
      logic [SEL_W-1:0] rs2_sel;
      logic             valid;
      logic             load_regfile;
      logic             taken;
   } idex_t;

   function automatic logic in_range(input logic [4:0] idx);
      return {1'b0, idx} < 6'(NUM_REGS);
   endfunction

   logic [XLEN-1:0] instr;
   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2, rd;
   logic            rs1_used, rs2_used, writes_rd, load_regfile_dec;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_dec;

   assign instr  = bus.instr_IFID;
   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];

   always_comb begin
      rs1_used  = 1'b1;
      rs2_used  = 1'b0;
      writes_rd = 1'b0;
      imm32     = '0;
      case (opcode)
         OP_LUI, OP_AUIPC: begin
            rs1_used  = 1'b0;
            writes_rd = 1'b1;
            imm32     = {instr[31:12], 12'b0};
         end
         OP_JAL: begin
            rs1_used  = 1'b0;
            writes_rd = 1'b1;
            imm32     = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         OP_JALR, OP_LOAD, OP_IMM: begin
            writes_rd = 1'b1;
            imm32     = {{21{instr[31]}}, instr[30:20]};
         end
         OP_STORE: begin
            rs2_used = 1'b1;
            imm32    = {{21{instr[31]}}, instr[30:25], instr[11:7]};
         end
         OP_BR: begin
            rs2_used = 1'b1;
            imm32    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OP_REG: begin
            rs2_used  = 1'b1;
            writes_rd = 1'b1;
         end
         default: ;
      endcase
      load_regfile_dec = writes_rd && (rd != 5'd0);
   end

   assign imm_dec = XLEN'($signed(imm32));

   // Register file; x0 is never written and is masked on read.
   logic [XLEN-1:0] rf [NUM_REGS];
   logic            wb_we;

   assign wb_we = bus.wb_load && bus.wb_rd != 5'd0 && in_range(bus.wb_rd);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (wb_we) begin
         rf[bus.wb_rd[IDX_W-1:0]] <= bus.wb_data;
      end
   end

   // Per-source read, forwarding select and hazard match; source 0 = rs1, 1 = rs2.
   logic [1:0][4:0]       rs_idx;
   logic [1:0]            rs_used;
   logic [1:0][XLEN-1:0]  rd_data;
   logic [1:0][SEL_W-1:0] sel;
   logic [1:0]            lu_hit;
   logic [4:0]            fwd_rd0;

   assign rs_idx  = {rs2, rs1};
   assign rs_used = {rs2_used, rs1_used};
   assign fwd_rd0 = bus.fwd_rd[4:0];

`ifndef RF_BYPASS_EN
   logic [1:0] wb_hit;
`endif

   for (genvar s = 0; s < 2; s++) begin : g_src
      logic [XLEN-1:0] data;

      always_comb begin
         data = '0;
         if (rs_idx[s] != 5'd0 && in_range(rs_idx[s]))
            data = rf[rs_idx[s][IDX_W-1:0]];
`ifdef RF_BYPASS_EN
         if (wb_we && bus.wb_rd == rs_idx[s])
            data = bus.wb_data;
`endif
      end

      assign rd_data[s] = data;
      assign lu_hit[s]  = rs_used[s] && (fwd_rd0 == rs_idx[s]);
`ifndef RF_BYPASS_EN
      assign wb_hit[s]  = rs_used[s] && (bus.wb_rd == rs_idx[s]);
`endif

      decode_fwd_sel #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_fwd_sel (
         .rs               (rs_idx[s]),
         .used             (rs_used[s]),
         .fwd_load_regfile (bus.fwd_load_regfile),
         .fwd_rd           (bus.fwd_rd),
         .sel              (sel[s])
      );
   end

   logic load_use, hazard;

   assign load_use = bus.valid_IFID && bus.fwd_mem_read[0] && bus.fwd_load_regfile[0] &&
                     (fwd_rd0 != 5'd0) && (|lu_hit);
`ifdef RF_BYPASS_EN
   assign hazard = load_use;
`else
   assign hazard = load_use || (bus.wb_load && bus.wb_rd != 5'd0 && (|wb_hit));
`endif
   assign bus.hazard_stall = hazard;

   // ID/EX register: reset/flush, then stall hold, then bubble, then load.
   idex_t idex_d, idex_q;

   always_comb begin
      idex_d              = '0;
      idex_d.rs1_data     = rd_data[0];
      idex_d.rs2_data     = rd_data[1];
      idex_d.imm          = imm_dec;
      idex_d.pc_addr      = bus.pc_addr_IFID;
      idex_d.rd           = rd;
      idex_d.funct3       = instr[14:12];
      idex_d.funct7       = instr[31:25];
      idex_d.opcode       = opcode;
      idex_d.rs1_sel      = sel[0];
      idex_d.rs2_sel      = sel[1];
      idex_d.valid        = bus.valid_IFID;
      idex_d.load_regfile = bus.valid_IFID && load_regfile_dec;
      idex_d.taken        = bus.taken_IFID;
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush)  idex_q <= '0;
      else if (bus.stall)    idex_q <= idex_q;
      else if (hazard)       idex_q <= '0;
      else                   idex_q <= idex_d;
   end

   assign bus.rs1_data_IDEX     = idex_q.rs1_data;
   assign bus.rs2_data_IDEX     = idex_q.rs2_data;
   assign bus.imm_IDEX          = idex_q.imm;
   assign bus.pc_addr_IDEX      = idex_q.pc_addr;
   assign bus.rd_IDEX           = idex_q.rd;
   assign bus.funct3_IDEX       = idex_q.funct3;
   assign bus.funct7_IDEX       = idex_q.funct7;
   assign bus.opcode_IDEX       = idex_q.opcode;
   assign bus.rs1_sel_IDEX      = idex_q.rs1_sel;
   assign bus.rs2_sel_IDEX      = idex_q.rs2_sel;
   assign bus.valid_IDEX        = idex_q.valid;
   assign bus.load_regfile_IDEX = idex_q.load_regfile;
   assign bus.taken_IDEX        = idex_q.taken;
endmodule

// File: tb/tb_decode_fwd_stage.sv
// Bench for decode_fwd_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an instruction-level model.
module tb_decode_fwd_stage;
   localparam int XLEN      = 32;
   localparam int NUM_REGS  = 32;
   localparam int FWD_DEPTH = 2;
   localparam int SEL_W     = $clog2(FWD_DEPTH + 1);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   decode_fwd_stage_if #(.XLEN(XLEN), .FWD_DEPTH(FWD_DEPTH)) b ();

   decode_fwd_stage #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .FWD_DEPTH(FWD_DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] rs1_data, rs2_data, imm, pc;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [6:0]  f7, op;
      logic [1:0]  s1, s2;
      logic        v, lr, tk;
   } exp_t;

   logic [31:0] mrf [NUM_REGS];
   exp_t        exp_q, nxt;
   bit          model_ok = 1'b0;

   function automatic bit uses1(input logic [6:0] op);
      return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
   endfunction
   function automatic bit uses2(input logic [6:0] op);
      return op == OP_REG || op == OP_STORE || op == OP_BR;
   endfunction
   function automatic bit writes(input logic [6:0] op);
      return op inside {OP_REG, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
   endfunction

   // Immediates built arithmetically: signed top part scaled plus the unsigned low pieces.
   function automatic logic [31:0] model_imm(input logic [31:0] ins);
      int sx20, sx25, sx31;
      sx20 = $signed(ins); sx20 = sx20 >>> 20;
      sx25 = $signed(ins); sx25 = sx25 >>> 25;
      sx31 = $signed(ins); sx31 = sx31 >>> 31;
      case (ins[6:0])
         OP_LOAD, OP_IMM, OP_JALR: return sx20;
         OP_STORE: return sx25 * 32 + int'(ins[11:7]);
         OP_BR:    return sx31 * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
         OP_LUI, OP_AUIPC: return ins & 32'hFFFF_F000;
         OP_JAL:   return sx31 * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
         default:  return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
      if (b.wb_load && b.wb_rd == idx) return b.wb_data;
`endif
      return mrf[idx];
   endfunction

   function automatic logic [1:0] model_sel(input logic [4:0] rs, input bit used);
      if (!used || rs == 5'd0) return 2'd0;
      for (int k = 0; k < FWD_DEPTH; k++)
         if (b.fwd_load_regfile[k] && b.fwd_rd[5*k +: 5] == rs) return 2'(k + 1);
      return 2'd0;
   endfunction

   function automatic bit model_hazard();
      logic [6:0] op;
      logic [4:0] r1, r2, lrd;
      bit h;
      op  = b.instr_IFID[6:0];
      r1  = b.instr_IFID[19:15];
      r2  = b.instr_IFID[24:20];
      lrd = b.fwd_rd[4:0];
      h = b.valid_IFID && b.fwd_mem_read[0] && b.fwd_load_regfile[0] && lrd != 0 &&
          ((uses1(op) && r1 == lrd) || (uses2(op) && r2 == lrd));
`ifndef RF_BYPASS_EN
      if (b.wb_load && b.wb_rd != 0 &&
          ((uses1(op) && r1 == b.wb_rd) || (uses2(op) && r2 == b.wb_rd))) h = 1'b1;
`endif
      return h;
   endfunction

   // Compare on the falling edge, then advance the model with the inputs of this cycle.
   initial forever begin
      logic [31:0] ins;
      bit hz;
      @(negedge clk);
      hz = model_hazard();
      if (model_ok) begin
         chk("hazard_stall", 64'(b.hazard_stall), 64'(hz));
         chk("rs1_data",     64'(b.rs1_data_IDEX), 64'(exp_q.rs1_data));
         chk("rs2_data",     64'(b.rs2_data_IDEX), 64'(exp_q.rs2_data));
         chk("imm",          64'(b.imm_IDEX),      64'(exp_q.imm));
         chk("pc_addr",      64'(b.pc_addr_IDEX),  64'(exp_q.pc));
         chk("rd",           64'(b.rd_IDEX),       64'(exp_q.rd));
         chk("funct3",       64'(b.funct3_IDEX),   64'(exp_q.f3));
         chk("funct7",       64'(b.funct7_IDEX),   64'(exp_q.f7));
         chk("opcode",       64'(b.opcode_IDEX),   64'(exp_q.op));
         chk("rs1_sel",      64'(b.rs1_sel_IDEX),  64'(exp_q.s1));
         chk("rs2_sel",      64'(b.rs2_sel_IDEX),  64'(exp_q.s2));
         chk("valid",        64'(b.valid_IDEX),    64'(exp_q.v));
         chk("load_regfile", 64'(b.load_regfile_IDEX), 64'(exp_q.lr));
         chk("taken",        64'(b.taken_IDEX),    64'(exp_q.tk));
      end
      ins = b.instr_IFID;
      if (rst || b.flush)  nxt = '0;
      else if (b.stall)    nxt = exp_q;
      else if (hz)         nxt = '0;
      else begin
         nxt.rs1_data = model_read(ins[19:15]);
         nxt.rs2_data = model_read(ins[24:20]);
         nxt.imm      = model_imm(ins);
         nxt.pc       = b.pc_addr_IFID;
         nxt.rd       = ins[11:7];
         nxt.f3       = ins[14:12];
         nxt.f7       = ins[31:25];
         nxt.op       = ins[6:0];
         nxt.s1       = model_sel(ins[19:15], uses1(ins[6:0]));
         nxt.s2       = model_sel(ins[24:20], uses2(ins[6:0]));
         nxt.v        = b.valid_IFID;
         nxt.lr       = b.valid_IFID && writes(ins[6:0]) && ins[11:7] != 0;
         nxt.tk       = b.taken_IFID;
      end
      if (rst) foreach (mrf[i]) mrf[i] = 32'd0;
      else if (b.wb_load && b.wb_rd != 0) mrf[b.wb_rd] = b.wb_data;
      exp_q = nxt;
      if (rst) model_ok = 1'b1;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b.stall = 0; b.flush = 0;
      b.instr_IFID = 32'h0000_0013; b.pc_addr_IFID = '0;
      b.valid_IFID = 0; b.taken_IFID = 0;
      b.wb_load = 0; b.wb_rd = '0; b.wb_data = '0;
      b.fwd_load_regfile = '0; b.fwd_mem_read = '0; b.fwd_rd = '0;
   endtask

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rd);
      return {f7, r2, r1, f3, rd, OP_REG};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [10];
      logic [31:0] ins;
      ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE, OP_IMM, OP_REG, 7'h73};
      ins        = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      return ins;
   endfunction

   initial begin
      rst = 1'b1;
      idle();
      tick(); tick();
      rst = 1'b0;

      // reset mid-stream with an add in flight and a pending x5 write
      b.wb_load = 1; b.wb_rd = 5'd5; b.wb_data = 32'h55;
      b.instr_IFID = r_type(7'd0, 5'd5, 5'd5, 3'd0, 5'd6); b.valid_IFID = 1; b.pc_addr_IFID = 32'h100;
      tick();
      b.wb_load = 0; rst = 1'b1;
      tick();
      chk("rst valid",   64'(b.valid_IDEX), 64'd0);
      chk("rst rd",      64'(b.rd_IDEX), 64'd0);
      chk("rst pc",      64'(b.pc_addr_IDEX), 64'd0);
      chk("rst opcode",  64'(b.opcode_IDEX), 64'd0);
      rst = 1'b0;
      tick();
      chk("x5 after rst", 64'(b.rs1_data_IDEX), 64'd0);
      chk("add valid",    64'(b.valid_IDEX), 64'd1);

      // regfile write then read
      b.valid_IFID = 0; b.wb_load = 1; b.wb_rd = 5'd5; b.wb_data = 32'h1234;
      tick();
      b.wb_load = 0; b.valid_IFID = 1;
      tick();
      chk("add rs1", 64'(b.rs1_data_IDEX), 64'h1234);
      chk("add rs2", 64'(b.rs2_data_IDEX), 64'h1234);
      chk("add sel1", 64'(b.rs1_sel_IDEX), 64'd0);
      chk("add lr",  64'(b.load_regfile_IDEX), 64'd1);

      // nearest forwarding stage wins
      b.fwd_load_regfile = 2'b11; b.fwd_rd = {5'd7, 5'd7};
      b.instr_IFID = r_type(7'b0100000, 5'd2, 5'd7, 3'd0, 5'd1);
      tick();
      chk("sub sel1 near", 64'(b.rs1_sel_IDEX), 64'd1);
      chk("sub sel2",      64'(b.rs2_sel_IDEX), 64'd0);
      b.fwd_rd = {5'd7, 5'd3};
      tick();
      chk("sub sel1 far",  64'(b.rs1_sel_IDEX), 64'd2);

      // load-use: one bubble, then forward from stage 1
      b.fwd_load_regfile = 2'b01; b.fwd_mem_read = 2'b01; b.fwd_rd = {5'd0, 5'd3};
      b.instr_IFID = {12'd1, 5'd3, 3'd0, 5'd4, OP_IMM};
      #1;
      chk("lu hazard", 64'(b.hazard_stall), 64'd1);
      tick();
      chk("lu bubble", 64'(b.valid_IDEX), 64'd0);
      b.fwd_load_regfile = 2'b10; b.fwd_mem_read = 2'b10; b.fwd_rd = {5'd3, 5'd0};
      #1;
      chk("lu clear", 64'(b.hazard_stall), 64'd0);
      tick();
      chk("addi valid", 64'(b.valid_IDEX), 64'd1);
      chk("addi sel1",  64'(b.rs1_sel_IDEX), 64'd2);
      chk("addi imm",   64'(b.imm_IDEX), 64'd1);

      // same-cycle WB to a read index
      b.fwd_load_regfile = '0; b.fwd_mem_read = '0; b.fwd_rd = '0;
      b.wb_load = 1; b.wb_rd = 5'd9; b.wb_data = 32'hABCD;
      b.instr_IFID = r_type(7'd0, 5'd0, 5'd9, 3'b110, 5'd1);
      #1;
`ifdef RF_BYPASS_EN
      chk("wb hazard", 64'(b.hazard_stall), 64'd0);
      tick();
      chk("or rs1 bypass", 64'(b.rs1_data_IDEX), 64'hABCD);
      b.wb_load = 0;
`else
      chk("wb hazard", 64'(b.hazard_stall), 64'd1);
      tick();
      chk("wb bubble", 64'(b.valid_IDEX), 64'd0);
      b.wb_load = 0;
      tick();
      chk("or rs1 after", 64'(b.rs1_data_IDEX), 64'hABCD);
`endif

      // stall+flush clears; stall alone holds; lui x0
      b.stall = 1; b.flush = 1;
      tick();
      chk("flush valid", 64'(b.valid_IDEX), 64'd0);
      chk("flush rd",    64'(b.rd_IDEX), 64'd0);
      b.stall = 0; b.flush = 0;
      b.instr_IFID = r_type(7'd0, 5'd5, 5'd5, 3'd0, 5'd6);
      tick();
      b.stall = 1;
      b.instr_IFID = r_type(7'b0100000, 5'd2, 5'd7, 3'd0, 5'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall rd",  64'(b.rd_IDEX), 64'd6);
         chk("stall rs1", 64'(b.rs1_data_IDEX), 64'h1234);
      end
      b.stall = 0;
      b.instr_IFID = {20'hFEDCB, 5'd0, OP_LUI};
      tick();
      chk("lui x0 lr",  64'(b.load_regfile_IDEX), 64'd0);
      chk("lui imm",    64'(b.imm_IDEX), 64'hFEDC_B000);
      chk("lui valid",  64'(b.valid_IDEX), 64'd1);

      // randomized traffic, checked by the model every cycle
      for (int n = 0; n < 3000; n++) begin
         rst                = ($urandom_range(0, 199) == 0);
         b.stall            = ($urandom_range(0, 9) == 0);
         b.flush            = ($urandom_range(0, 15) == 0);
         b.instr_IFID       = rand_instr();
         b.pc_addr_IFID     = $urandom;
         b.valid_IFID       = ($urandom_range(0, 3) != 0);
         b.taken_IFID       = 1'($urandom_range(0, 1));
         b.wb_load          = 1'($urandom_range(0, 1));
         b.wb_rd            = 5'($urandom_range(0, 7));
         b.wb_data          = $urandom;
         b.fwd_load_regfile = 2'($urandom_range(0, 3));
         b.fwd_mem_read     = 2'($urandom_range(0, 3));
         b.fwd_rd           = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         tick();
      end
      rst = 1'b0;
      idle();
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/decode_fwd_stage.md
# decode_fwd_stage

Parametrised instruction-decode stage for the pipelined RV32I core, sitting between the IF/ID and ID/EX pipeline registers. It holds the register file and decodes rs1/rs2/rd/funct fields and a pre-selected immediate. Forwarding-source selection covers a configurable number of downstream stages, and load-use hazards are detected internally by inserting a bubble into ID/EX. The ID/EX register carries a valid bit and honours downstream stall and flush.

## Interface
- XLEN, 32, datapath width
- NUM_REGS, 32, architectural registers (power of two, ≤32); x0 hard-wired zero
- FWD_DEPTH, 2, number of downstream forwarding sources (1..4); SEL_W = $clog2(FWD_DEPTH+1)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  downstream stall; hold ID/EX
- flush  in  1  squash ID/EX contents (branch mispredict)
- instr_IFID, pc_addr_IFID  in  XLEN  instruction and PC from IF/ID
- valid_IFID, taken_IFID  in  1  IF/ID valid; predicted-taken flag
- wb_load  in  1  register write enable from WB
- wb_rd  in  5  write index
- wb_data  in  XLEN  write data
- fwd_load_regfile  in  FWD_DEPTH  stage k writes rd (k=0 nearest, i.e. ID/EX)
- fwd_mem_read  in  FWD_DEPTH  stage k is a load
- fwd_rd  in  5*FWD_DEPTH  stage k destination, packed, stage k at [5k+4:5k]
- hazard_stall  out  1  combinational; IF and IF/ID must hold this cycle
- rs1_data_IDEX, rs2_data_IDEX, imm_IDEX, pc_addr_IDEX  out  XLEN  registered
- rd_IDEX  out  5; funct3_IDEX  out  3; funct7_IDEX  out  7; opcode_IDEX  out  7
- rs1_sel_IDEX, rs2_sel_IDEX  out  SEL_W  forwarding select: 0 = regfile, k+1 = stage k
- valid_IDEX, load_regfile_IDEX, taken_IDEX  out  1

## Operation
- Decode: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7]. rs1 used by all opcodes except lui, auipc, jal; rs2 used by op_reg, op_store, op_br.
- Immediate: I for load/imm/jalr, S for store, B for br, U for lui/auipc, J for jal, else 0; sign extension is from instr[31].
- load_regfile = 1 for reg/imm/load/lui/auipc/jal/jalr when rd≠0, else 0.
- Forward select per source: the lowest k with fwd_load_regfile[k] && fwd_rd[k]==rs && rs≠0 && rs used gives sel=k+1; if no k matches, sel=0. The nearest stage wins.
- Load-use: hazard_stall=1 when valid_IFID && fwd_mem_read[0] && fwd_load_regfile[0] && fwd_rd[0]≠0 && fwd_rd[0] matches a used rs.
- Regfile: writes on posedge when wb_load && wb_rd≠0 && wb_rd<NUM_REGS. Reads of x0 or of an index ≥NUM_REGS return 0.
- ID/EX update priority per posedge:
  - rst or flush: clear everything.
  - else stall: hold all fields.
  - else hazard_stall: bubble (valid_IDEX=0, load_regfile_IDEX=0; other fields don't-care, driven 0).
  - else load decoded fields; valid_IDEX = valid_IFID. An invalid input forces load_regfile_IDEX=0.

## Timing
- Reset: every output 0. The regfile is cleared to 0 over the same reset cycle.
- Latency: 1 cycle from IF/ID to ID/EX. hazard_stall is same-cycle combinational from current inputs.
- Load-use costs exactly one bubble. On the following cycle the load sits in stage 1, and the consumer issues with sel=2.
- stall && hazard_stall: stall wins and ID/EX holds. hazard_stall stays high, so IF also holds.
- flush && hazard_stall: flush wins and ID/EX clears. hazard_stall is still asserted; IF handles the redirect itself.
- Simultaneous WB write and same-index read: see Configuration.

## Configuration
- RF_BYPASS_EN defined: regfile reads are write-through. A same-cycle wb_load to a read index returns wb_data, so there is no extra stall.
- RF_BYPASS_EN undefined: reads return the old value. hazard_stall is also asserted when wb_load && wb_rd≠0 && wb_rd matches a used rs, costing one bubble, after which the new value is read.

## Test plan
- Reset mid-stream: assert rst for 1 cycle with a valid add in flight -> next cycle every output is 0, and a read of x5 returns 0.
- Write x5=0x1234 via WB, then decode add x6,x5,x5 -> rs1_data_IDEX=rs2_data_IDEX=0x1234, sel=0, valid_IDEX=1, load_regfile_IDEX=1.
- fwd stage 0 and stage 1 both write x7 (FWD_DEPTH=2), decode sub x1,x7,x2 -> rs1_sel_IDEX=1, rs2_sel_IDEX=0; with stage 0 not matching -> rs1_sel_IDEX=2.
- lw x3 in stage 0 (fwd_mem_read[0]=1), decode addi x4,x3,1 -> hazard_stall=1 and one bubble with valid_IDEX=0. The next cycle with the load in stage 1 gives the addi with rs1_sel_IDEX=2 and imm_IDEX=1.
- Same-cycle WB x9=0xABCD with decode of or x1,x9,x0. With RF_BYPASS_EN -> rs1_data_IDEX=0xABCD and no stall. Without it -> one bubble, then 0xABCD.
- stall=1 and flush=1 together -> ID/EX clears; stall=1 alone for 3 cycles -> outputs unchanged throughout; lui x0 -> load_regfile_IDEX=0 and imm_IDEX=instr[31:12]<<12.
